interval_timer_ctrl: RTL and testbench

//  Sequencer for one `counter` instance, making it a programmable interval timer.

---
 rtl/interval_timer_ctrl_pkg.sv | 12 +
 rtl/counter.sv | 43 ++++
 rtl/interval_timer_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_ctrl_pkg.sv
// rtl/interval_timer_ctrl_pkg.sv - shared state encoding for the interval timer sequencer
package interval_timer_ctrl_pkg;

    localparam int TIMER_STATE_W = 2;

    typedef enum logic [TIMER_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } timer_state_t;

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - loadable up-counter with sticky out-of-range (carry-out) flag
//
// Ports:
//   clk, a_reset_n   clock, asynchronous active-low reset
//   reset            synchronous clear (highest synchronous priority)
//   load, load_data  preload the count and clear out_of_range
//   increment        count up by one; a carry out of the top bit sets out_of_range
//   count            current count value
//   out_of_range     sticky, set when the count wraps past all-ones
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             a_reset_n,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             increment,
    output logic [WIDTH-1:0] count,
    output logic             out_of_range
);

    logic [WIDTH:0] count_inc;

    assign count_inc = {1'b0, count} + (WIDTH+1)'(1);

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            count        <= '0;
            out_of_range <= 1'b0;
        end else if (reset) begin
            count        <= '0;
            out_of_range <= 1'b0;
        end else if (load) begin
            count        <= load_data;
            out_of_range <= 1'b0;
        end else if (increment) begin
            count        <= count_inc[WIDTH-1:0];
            out_of_range <= out_of_range | count_inc[WIDTH];
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - programmable interval timer sequencer around one counter
//
// Ports:
//   clk, a_reset_n   clock, asynchronous active-low reset
//   reset            synchronous soft reset, same effect as a_reset_n
//   start / stop     pulses: arm from IDLE / abort to IDLE
//   pause            level: freeze prescaler and counter while high
//   mode_periodic    1 = auto-reload on expiry, 0 = one-shot (sampled at load)
//   period           ticks per interval, 0 means 2^COUNT_WIDTH (sampled at load)
//   prescale         one tick every prescale+1 clocks (sampled at load)
//   irq_clear        pulse: clear irq
//   busy, paused     state != IDLE, state == PAUSED
//   expire           one-cycle pulse per expiry
//   irq              sticky expiry flag
//   expire_count     saturating expiry count since start
//   elapsed          ticks elapsed in the current interval
module interval_timer_ctrl
    import interval_timer_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int PRE_WIDTH   = 8,
    parameter int EXP_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   a_reset_n,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   mode_periodic,
    input  logic [COUNT_WIDTH-1:0] period,
    input  logic [PRE_WIDTH-1:0]   prescale,
    input  logic                   irq_clear,
    output logic                   busy,
    output logic                   paused,
    output logic                   expire,
    output logic                   irq,
    output logic [EXP_WIDTH-1:0]   expire_count,
    output logic [COUNT_WIDTH-1:0] elapsed
);

    timer_state_t state, state_nxt;

    logic [COUNT_WIDTH-1:0] sh_period;
    logic [PRE_WIDTH-1:0]   sh_prescale;
    logic                   sh_mode;
    logic [PRE_WIDTH-1:0]   pre_cnt;

    logic                   do_load;
    logic                   clr_count;
    logic                   expire_c;
    logic                   advance;
    logic                   tick;
    logic                   cnt_reset;
    logic                   cnt_inc;
    logic [COUNT_WIDTH-1:0] cnt_load_data;
    logic [COUNT_WIDTH-1:0] cnt_count;
    logic                   cnt_oor;

    // Preloading with -period makes the carry out of the top bit land after
    // exactly `period` increments; period 0 loads 0 and so takes 2^W ticks.
    assign cnt_load_data = (~period) + COUNT_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        clr_count = 1'b0;
        expire_c  = 1'b0;
        if (reset) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        do_load   = 1'b1;
                        clr_count = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN, ST_PAUSED: begin
                    if (stop) begin
                        state_nxt = ST_IDLE;
                    end else if (cnt_oor) begin
                        expire_c = 1'b1;
                        if (sh_mode) begin
                            do_load   = 1'b1;
                            state_nxt = ST_RUN;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else if (pause) begin
                        state_nxt = ST_PAUSED;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Freezing follows the pause level rather than the PAUSED state so that a
    // pause of N cycles delays expiry by exactly N cycles.
    assign advance   = (state != ST_IDLE) && !reset && !stop && !pause && !cnt_oor;
    assign tick      = (pre_cnt == sh_prescale);
    assign cnt_inc   = advance && tick;
    assign cnt_reset = reset || ((state == ST_IDLE) && !do_load);

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            pre_cnt <= '0;
        end else if (reset || do_load || (state == ST_IDLE)) begin
            pre_cnt <= '0;
        end else if (advance) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            sh_period   <= '0;
            sh_prescale <= '0;
            sh_mode     <= 1'b0;
        end else if (reset) begin
            sh_period   <= '0;
            sh_prescale <= '0;
            sh_mode     <= 1'b0;
        end else if (do_load) begin
            sh_period   <= period;
            sh_prescale <= prescale;
            sh_mode     <= mode_periodic;
        end
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            expire_count <= '0;
        end else if (reset || clr_count) begin
            expire_count <= '0;
        end else if (expire_c && !(&expire_count)) begin
            expire_count <= expire_count + EXP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            irq <= 1'b0;
        end else if (reset) begin
            irq <= 1'b0;
        end else if (expire_c) begin
            irq <= 1'b1;
        end else if (irq_clear) begin
            irq <= 1'b0;
        end
    end

    counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_counter (
        .clk          (clk),
        .a_reset_n    (a_reset_n),
        .reset        (cnt_reset),
        .load         (do_load),
        .load_data    (cnt_load_data),
        .increment    (cnt_inc),
        .count        (cnt_count),
        .out_of_range (cnt_oor)
    );

    assign busy    = (state != ST_IDLE);
    assign paused  = (state == ST_PAUSED);
    assign expire  = expire_c;
    assign elapsed = busy ? (cnt_count + sh_period) : '0;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - scoreboard bench for interval_timer_ctrl
module tb_interval_timer_ctrl;

    localparam int CW = 8;
    localparam int PW = 8;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          a_reset_n;
    logic          reset;
    logic          start;
    logic          stop;
    logic          pause;
    logic          mode_periodic;
    logic [CW-1:0] period;
    logic [PW-1:0] prescale;
    logic          irq_clear;
    logic          busy;
    logic          paused;
    logic          expire;
    logic          irq;
    logic [EW-1:0] expire_count;
    logic [CW-1:0] elapsed;

    interval_timer_ctrl #(
        .COUNT_WIDTH(CW),
        .PRE_WIDTH  (PW),
        .EXP_WIDTH  (EW)
    ) dut (
        .clk          (clk),
        .a_reset_n    (a_reset_n),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .mode_periodic(mode_periodic),
        .period       (period),
        .prescale     (prescale),
        .irq_clear    (irq_clear),
        .busy         (busy),
        .paused       (paused),
        .expire       (expire),
        .irq          (irq),
        .expire_count (expire_count),
        .elapsed      (elapsed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cycle;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push_exp(input int c, input int n);
        exp_t e;
        e.cycle = c;
        e.count = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every expire pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (expire) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_expire: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (cyc != e.cycle) begin
                    errors++;
                    $display("FAIL expire_cycle: got %0d expected %0d", cyc, e.cycle);
                end
                checks++;
                if (int'(expire_count) != e.count) begin
                    errors++;
                    $display("FAIL expire_count_at_pulse: got %0d expected %0d", expire_count, e.count);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_irq_clear();
        irq_clear = 1'b1;
        step();
        irq_clear = 1'b0;
        chk("irq_cleared", int'(irq), 0);
    endtask

    // Drives start in the current cycle and returns that cycle number.
    task automatic do_start(input int p, input int s, input logic m, output int cs);
        period        = CW'(p);
        prescale      = PW'(s);
        mode_periodic = m;
        cs            = cyc;
        start         = 1'b1;
        step();
        start         = 1'b0;
    endtask

    int cs;

    initial begin
        a_reset_n = 1'b0; reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode_periodic = 1'b0; period = '0; prescale = '0; irq_clear = 1'b0;
        step(); step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_expire", int'(expire), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_expire_count", int'(expire_count), 0);
        chk("rst_elapsed", int'(elapsed), 0);
        a_reset_n = 1'b1;
        step(); step();

        // 1: one-shot, period 5, prescale 0
        do_start(5, 0, 1'b0, cs);
        push_exp(cs + 6, 0);
        wait_to(cs + 3);
        chk("t1_elapsed", int'(elapsed), 2);
        wait_to(cs + 6);
        chk("t1_busy_at_expiry", int'(busy), 1);
        wait_to(cs + 7);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_expire_count", int'(expire_count), 1);
        chk("t1_irq", int'(irq), 1);
        pulse_irq_clear();

        // 2: periodic, period 3, prescale 2; period changed to 1 mid-run
        do_start(3, 2, 1'b1, cs);
        push_exp(cs + 10, 0);
        push_exp(cs + 20, 1);
        push_exp(cs + 30, 2);
        push_exp(cs + 34, 3);
        wait_to(cs + 14);
        chk("t2_elapsed", int'(elapsed), 1);
        wait_to(cs + 25);
        period = CW'(1);
        wait_to(cs + 36);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t2_busy_after_stop", int'(busy), 0);
        chk("t2_expire_count_sat", int'(expire_count), 3);
        pulse_irq_clear();

        // 3: period 0 means 256 ticks
        do_start(0, 0, 1'b0, cs);
        push_exp(cs + 257, 0);
        wait_to(cs + 256);
        chk("t3_elapsed_255", int'(elapsed), 255);
        wait_to(cs + 258);
        chk("t3_busy_after", int'(busy), 0);

        // 4: 7-cycle pause delays expiry by 7; expiry with pause high still serviced; stop while paused
        do_start(4, 0, 1'b1, cs);
        push_exp(cs + 12, 0);
        push_exp(cs + 17, 1);
        wait_to(cs + 2);
        pause = 1'b1;
        wait_to(cs + 5);
        chk("t4_paused", int'(paused), 1);
        chk("t4_elapsed_frozen", int'(elapsed), 1);
        wait_to(cs + 9);
        pause = 1'b0;
        wait_to(cs + 10);
        chk("t4_resumed", int'(paused), 0);
        wait_to(cs + 17);
        pause = 1'b1;
        wait_to(cs + 20);
        chk("t4_paused_again", int'(paused), 1);
        wait_to(cs + 21);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_idle_after_stop", int'(busy), 0);
        chk("t4_paused_after_stop", int'(paused), 0);
        wait_to(cs + 23);
        pause = 1'b0;
        wait_to(cs + 40);
        pulse_irq_clear();

        // 5a: stop in the expiry cycle suppresses the pulse
        do_start(2, 0, 1'b0, cs);
        wait_to(cs + 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t5_irq_after_stop", int'(irq), 0);
        chk("t5_busy_after_stop", int'(busy), 0);
        chk("t5_count_after_stop", int'(expire_count), 0);

        // 5b: irq_clear in expiry cycle loses; start while busy ignored
        do_start(2, 0, 1'b1, cs);
        push_exp(cs + 3, 0);
        push_exp(cs + 6, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_to(cs + 3);
        irq_clear = 1'b1;
        step();
        irq_clear = 1'b0;
        chk("t5_irq_set_wins", int'(irq), 1);
        wait_to(cs + 5);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_to(cs + 7);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t5_count_kept", int'(expire_count), 2);

        // 6a: asynchronous reset mid-run
        do_start(3, 0, 1'b1, cs);
        wait_to(cs + 2);
        a_reset_n = 1'b0;
        #1;
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_irq", int'(irq), 0);
        chk("t6_async_count", int'(expire_count), 0);
        chk("t6_async_elapsed", int'(elapsed), 0);
        step();
        a_reset_n = 1'b1;
        step();

        // 6b: synchronous reset mid-run
        do_start(2, 0, 1'b1, cs);
        wait_to(cs + 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_sync_busy", int'(busy), 0);
        chk("t6_sync_elapsed", int'(elapsed), 0);
        wait_to(cs + 8);

        // 6c: saturation at 3 after the 4th expiry
        do_start(1, 0, 1'b1, cs);
        push_exp(cs + 2, 0);
        push_exp(cs + 4, 1);
        push_exp(cs + 6, 2);
        push_exp(cs + 8, 3);
        wait_to(cs + 9);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t6_sat_count", int'(expire_count), 3);
        chk("t6_sat_irq", int'(irq), 1);
        step(); step();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
